// File: rtl/select_next_hop.sv
// Routing-table reader: scans the neighbor table in shared memory and
// returns the cheapest neighbor whose battery level meets the minimum.
module select_next_hop #(
    parameter logic [15:0] NCNT_ADDR     = 16'h068A,
    parameter logic [15:0] ID_BASE       = 16'h0048,
    parameter logic [15:0] BATT_BASE     = 16'h0148,
    parameter logic [15:0] Q_BASE        = 16'h01C8,
    parameter int          MAX_NEIGHBORS = 64,
    parameter logic [15:0] BATT_MIN      = 16'd10
) (
    input  logic        clock,
    input  logic        nrst,
    input  logic        start,
    input  logic [15:0] data_in,
    output logic [15:0] address,
    output logic [15:0] next_hop_id,
    output logic [15:0] best_cost,
    output logic        found,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        RD_NCNT,
        SCAN,
        RD_BATT,
        RD_Q,
        RD_ID,
        DONE
    } state_t;

    localparam logic [15:0] MAX_W = 16'(MAX_NEIGHBORS);
    localparam logic [6:0]  MAX_N = 7'(MAX_NEIGHBORS);

    state_t      state, state_nxt;
    logic [15:0] address_nxt;
    logic [15:0] id_nxt, cost_nxt;
    logic        found_nxt, done_nxt;
    logic [6:0]  ncnt, ncnt_nxt;
    logic [6:0]  n, n_nxt;
    logic [6:0]  best_n, best_n_nxt;
    logic [15:0] best_q, best_q_nxt;
    // Running "have a candidate" flag; found only publishes it at the end.
    logic        any, any_nxt;

    function automatic logic [15:0] offs(input logic [6:0] i);
        return {8'd0, i, 1'b0};
    endfunction

    always_ff @(posedge clock) begin
        if (!nrst) begin
            state       <= IDLE;
            address     <= NCNT_ADDR;
            next_hop_id <= 16'hFFFF;
            best_cost   <= 16'hFFFF;
            found       <= 1'b0;
            done        <= 1'b0;
            ncnt        <= '0;
            n           <= '0;
            best_n      <= '0;
            best_q      <= 16'hFFFF;
            any         <= 1'b0;
        end else begin
            state       <= state_nxt;
            address     <= address_nxt;
            next_hop_id <= id_nxt;
            best_cost   <= cost_nxt;
            found       <= found_nxt;
            done        <= done_nxt;
            ncnt        <= ncnt_nxt;
            n           <= n_nxt;
            best_n      <= best_n_nxt;
            best_q      <= best_q_nxt;
            any         <= any_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        address_nxt = address;
        id_nxt      = next_hop_id;
        cost_nxt    = best_cost;
        found_nxt   = found;
        done_nxt    = done;
        ncnt_nxt    = ncnt;
        n_nxt       = n;
        best_n_nxt  = best_n;
        best_q_nxt  = best_q;
        any_nxt     = any;
        case (state)
            IDLE: begin
                if (start) begin
                    address_nxt = NCNT_ADDR;
                    state_nxt   = RD_NCNT;
                end
            end
            RD_NCNT: begin
                ncnt_nxt   = (data_in > MAX_W) ? MAX_N : data_in[6:0];
                n_nxt      = '0;
                best_q_nxt = 16'hFFFF;
                any_nxt    = 1'b0;
                found_nxt  = 1'b0;
                state_nxt  = SCAN;
            end
            SCAN: begin
                if (n < ncnt) begin
                    address_nxt = BATT_BASE + offs(n);
                    state_nxt   = RD_BATT;
                end else if (any) begin
                    address_nxt = ID_BASE + offs(best_n);
                    state_nxt   = RD_ID;
                end else begin
                    id_nxt    = 16'hFFFF;
                    cost_nxt  = 16'hFFFF;
                    found_nxt = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end
            end
            RD_BATT: begin
                if (data_in < BATT_MIN) begin
                    n_nxt     = n + 7'd1;
                    state_nxt = SCAN;
                end else begin
                    address_nxt = Q_BASE + offs(n);
                    state_nxt   = RD_Q;
                end
            end
            RD_Q: begin
                // Strict compare keeps the lowest index on a tie.
                if (!any || data_in < best_q) begin
                    best_q_nxt = data_in;
                    best_n_nxt = n;
                    any_nxt    = 1'b1;
                end
                n_nxt     = n + 7'd1;
                state_nxt = SCAN;
            end
            RD_ID: begin
                id_nxt    = data_in;
                cost_nxt  = best_q;
                found_nxt = 1'b1;
                done_nxt  = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                if (!start) begin
                    done_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_select_next_hop.sv
// Randomized bench for select_next_hop against a table-walk reference
// model over a behavioural memory.
module tb_select_next_hop;

    localparam logic [15:0] NCNT_ADDR = 16'h068A;
    localparam logic [15:0] ID_BASE   = 16'h0048;
    localparam logic [15:0] BATT_BASE = 16'h0148;
    localparam logic [15:0] Q_BASE    = 16'h01C8;

    logic        clock = 1'b0;
    logic        nrst  = 1'b0;
    logic        start = 1'b0;
    logic [15:0] data_in;
    logic [15:0] address;
    logic [15:0] next_hop_id;
    logic [15:0] best_cost;
    logic        found;
    logic        done;

    logic [15:0] mem [0:65535];
    int checks = 0;
    int errors = 0;
    int addr_bad = 0;

    assign data_in = mem[address];

    select_next_hop dut (
        .clock       (clock),
        .nrst        (nrst),
        .start       (start),
        .data_in     (data_in),
        .address     (address),
        .next_hop_id (next_hop_id),
        .best_cost   (best_cost),
        .found       (found),
        .done        (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock)
        if (nrst && address != NCNT_ADDR && address >= Q_BASE + 16'd128)
            addr_bad <= addr_bad + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic put(input int i, input logic [15:0] id,
                       input logic [15:0] batt, input logic [15:0] q);
        mem[ID_BASE + 16'(2 * i)]   = id;
        mem[BATT_BASE + 16'(2 * i)] = batt;
        mem[Q_BASE + 16'(2 * i)]    = q;
    endtask

    // Reference: linear walk over the table, latency from counts.
    task automatic model(output logic m_found, output logic [15:0] m_id,
                         output logic [15:0] m_cost, output int m_lat);
        int cnt, best, e, i_cnt;
        logic [15:0] bq;
        cnt = int'(mem[NCNT_ADDR]);
        if (cnt > 64) cnt = 64;
        best = -1;
        bq = 16'hFFFF;
        e = 0;
        i_cnt = 0;
        for (int i = 0; i < cnt; i++) begin
            if (mem[BATT_BASE + 16'(2 * i)] < 16'd10) begin
                i_cnt++;
            end else begin
                e++;
                if (best < 0 || mem[Q_BASE + 16'(2 * i)] < bq) begin
                    best = i;
                    bq = mem[Q_BASE + 16'(2 * i)];
                end
            end
        end
        m_found = (best >= 0);
        m_id    = m_found ? mem[ID_BASE + 16'(2 * best)] : 16'hFFFF;
        m_cost  = m_found ? bq : 16'hFFFF;
        m_lat   = m_found ? 4 + 3 * e + 2 * i_cnt : 3 + 2 * i_cnt;
    endtask

    task automatic run_check(input string tag);
        logic        e_found;
        logic [15:0] e_id, e_cost, p_id, p_cost;
        int          e_lat, edges, bad0;
        bit          stable;
        model(e_found, e_id, e_cost, e_lat);
        bad0 = addr_bad;
        @(negedge clock);
        p_id = next_hop_id;
        p_cost = best_cost;
        start = 1'b1;
        edges = 0;
        stable = 1'b1;
        while (1) begin
            @(posedge clock);
            #1;
            edges++;
            if (done || edges > 1000) break;
            if (next_hop_id !== p_id || best_cost !== p_cost) stable = 1'b0;
        end
        check({tag, " latency"}, edges, e_lat);
        check({tag, " found"}, found, e_found);
        check({tag, " id"}, next_hop_id, e_id);
        check({tag, " cost"}, best_cost, e_cost);
        check({tag, " stable"}, stable, 1'b1);
        check({tag, " addr"}, addr_bad - bad0, 0);
        repeat (3) @(posedge clock);
        #1;
        check({tag, " hold done"}, done, 1'b1);
        check({tag, " hold id"}, next_hop_id, e_id);
        @(negedge clock);
        start = 1'b0;
        @(posedge clock);
        #1;
        check({tag, " drop"}, done, 1'b0);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
        repeat (2) @(posedge clock);
        #1;
        check("rst addr", address, NCNT_ADDR);
        check("rst id", next_hop_id, 16'hFFFF);
        check("rst cost", best_cost, 16'hFFFF);
        check("rst found", found, 1'b0);
        check("rst done", done, 1'b0);
        @(negedge clock);
        nrst = 1'b1;

        mem[NCNT_ADDR] = 16'd0;
        run_check("empty");

        mem[NCNT_ADDR] = 16'd3;
        put(0, 16'd5, 16'd50, 16'd30);
        put(1, 16'd9, 16'd50, 16'd12);
        put(2, 16'd12, 16'd50, 16'd20);
        run_check("basic");

        put(0, 16'd7, 16'd5, 16'd1);
        put(1, 16'd8, 16'd50, 16'd40);
        put(2, 16'd9, 16'd50, 16'd40);
        run_check("tie");

        mem[NCNT_ADDR] = 16'd2;
        put(0, 16'd3, 16'd10, 16'hFFFF);
        put(1, 16'd4, 16'd9, 16'd0);
        run_check("ffff");

        mem[NCNT_ADDR] = 16'd100;
        for (int i = 0; i < 100; i++)
            put(i, 16'(100 + i), 16'd20, 16'(200 - i));
        run_check("clamp");

        // Abort at RD_Q of the first neighbor, then rescan.
        @(negedge clock);
        start = 1'b1;
        repeat (4) @(posedge clock);
        @(negedge clock);
        nrst = 1'b0;
        start = 1'b0;
        @(posedge clock);
        #1;
        check("abort addr", address, NCNT_ADDR);
        check("abort id", next_hop_id, 16'hFFFF);
        check("abort cost", best_cost, 16'hFFFF);
        check("abort found", found, 1'b0);
        check("abort done", done, 1'b0);
        @(negedge clock);
        nrst = 1'b1;
        run_check("after abort");

        put(70, 16'd1, 16'd99, 16'd0);
        put(10, 16'hABCD, 16'd99, 16'd3);
        run_check("update");

        for (int t = 0; t < 40; t++) begin
            int cnt;
            cnt = $urandom_range(0, 20);
            if (t % 10 == 9) cnt = $urandom_range(60, 300);
            mem[NCNT_ADDR] = 16'(cnt);
            for (int i = 0; i < 64; i++) begin
                logic [15:0] q;
                q = 16'($urandom_range(0, 7));
                if ($urandom_range(0, 15) == 0) q = 16'hFFFF;
                put(i, 16'($urandom), 16'($urandom_range(0, 20)), q);
            end
            run_check($sformatf("rand%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
